// File: rtl/sdram_req_responder.sv
// Single-outstanding request responder: converts read_req/write_req/valid requests
// into Avalon-MM master commands, with range checking, read timeout and sticky errors.
module sdram_req_responder #(
    parameter int                ADDR_W       = 25,
    parameter int                DATA_W       = 32,
    parameter logic [ADDR_W:0]   MEM_WORDS    = 26'h2000000,
    parameter int                TIMEOUT      = 255,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              read_req,
    input  logic              write_req,
    input  logic [ADDR_W-1:0] address_to_sdram,
    input  logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic [DATA_W-1:0] data_from_sdram,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              clear_err,
    output logic              err_timeout,
    output logic              err_range,
    output logic              err_proto
);

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_WAIT,
        WR_CMD,
        RESP
    } state_t;

    // Counter value seen during the last permitted RD_WAIT cycle.
    localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT - 1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [9:0]        cnt;

    logic in_range;
    logic any_req;
    logic timeout_hit;
    logic range_set;
    logic proto_set;
    logic timeout_set;

    assign in_range    = ({1'b0, address_to_sdram} < MEM_WORDS);
    assign any_req     = read_req | write_req;
    assign timeout_hit = (cnt == TIMEOUT_LAST);
    assign range_set   = (state == IDLE) && any_req && !in_range;
    assign proto_set   = (state == IDLE) && read_req && write_req;
    assign timeout_set = (state == RD_WAIT) && !avm_readdatavalid && timeout_hit;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (!in_range)     next_state = RESP;
                    else if (read_req) next_state = RD_CMD;
                    else               next_state = WR_CMD;
                end
            end
            RD_CMD:  if (!avm_waitrequest) next_state = RD_WAIT;
            RD_WAIT: if (avm_readdatavalid || timeout_hit) next_state = RESP;
            WR_CMD:  if (!avm_waitrequest) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        avm_read        = (state == RD_CMD);
        avm_write       = (state == WR_CMD);
        valid           = (state == RESP);
        avm_address     = addr_q;
        avm_writedata   = wdata_q;
        data_from_sdram = rdata_q;
    end

    // Request latching, read data capture and the RD_WAIT timeout counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        rdata_q <= '0;
                        if (in_range) begin
                            addr_q <= address_to_sdram;
                            if (!read_req) wdata_q <= data_out;
                        end
                    end
                end
                RD_CMD: begin
                    if (!avm_waitrequest) cnt <= '0;
                end
                RD_WAIT: begin
                    cnt <= cnt + 10'd1;
                    if (avm_readdatavalid) rdata_q <= avm_readdata;
                    else if (timeout_hit)  rdata_q <= TIMEOUT_DATA;
                end
                default: ;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as clear_err takes priority.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            err_timeout <= 1'b0;
            err_range   <= 1'b0;
            err_proto   <= 1'b0;
        end else begin
            err_timeout <= timeout_set | (err_timeout & ~clear_err);
            err_range   <= range_set   | (err_range   & ~clear_err);
            err_proto   <= proto_set   | (err_proto   & ~clear_err);
        end
    end

endmodule
